// File: rtl/tx_frame_gearbox.sv
// Transmit 66b->32b gearbox: serialises {hdr,payload} frames MSB-first into 32-bit words, inserting idles.
// Optional SCRAMBLER_EN: self-synchronous 1+x^39+x^58 payload scrambler ahead of the bit buffer.
module tx_frame_gearbox #(
    parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000,
    parameter int unsigned INIT_IDLES   = 32,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [63:0]      data_i,
    input  logic [1:0]       hdr_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [31:0]      tx_word_o,
    output logic             init_done_o,
    output logic             hdr_err_o,
    output logic [CNT_W-1:0] underflow_cnt_o
);

    localparam int unsigned BUF_W  = 98;
    localparam int unsigned FILL_W = 7;
    localparam int unsigned IW     = (INIT_IDLES > 1) ? $clog2(INIT_IDLES) : 1;

    logic [BUF_W-1:0]  buf_q, buf_nxt, comb_buf;
    logic [FILL_W-1:0] f_q, f_nxt;
    logic [IW-1:0]     init_cnt_q, init_cnt_nxt;
    logic              load, accept, init_last, init_done_nxt;
    logic [1:0]        frame_hdr;
    logic [63:0]       frame_pay, pay_tx;
    logic [CNT_W-1:0]  ucnt_nxt;

`ifdef SCRAMBLER_EN
    logic [57:0] scr_q, scr_nxt;

    // Bit-serial scrambler unrolled over the payload, bit 63 first.
    always_comb begin
        logic b;
        scr_nxt = scr_q;
        pay_tx  = '0;
        for (int i = 63; i >= 0; i--) begin
            b         = frame_pay[i] ^ scr_nxt[38] ^ scr_nxt[57];
            pay_tx[i] = b;
            scr_nxt   = {scr_nxt[56:0], b};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     scr_q <= '1;
        else if (load) scr_q <= scr_nxt;
    end
`else
    assign pay_tx = frame_pay;
`endif

    // Slot decision, buffer append/shift and status next-state.
    always_comb begin
        load      = (f_q < FILL_W'(32));
        accept    = load & valid_i & ready_o;
        frame_hdr = accept ? hdr_i  : 2'b10;
        frame_pay = accept ? data_i : IDLE_PAYLOAD;

        comb_buf = buf_q;
        if (load)
            comb_buf = buf_q | ({frame_hdr, pay_tx, 32'b0} >> f_q);
        buf_nxt = comb_buf << 32;
        f_nxt   = load ? (f_q + FILL_W'(34)) : (f_q - FILL_W'(32));

        init_last     = (init_cnt_q == IW'(INIT_IDLES - 1));
        init_done_nxt = init_done_o | (load & init_last);
        init_cnt_nxt  = init_cnt_q;
        if (load && !init_done_o && !init_last)
            init_cnt_nxt = init_cnt_q + IW'(1);

        ucnt_nxt = underflow_cnt_o;
        if (load && init_done_o && !valid_i && (underflow_cnt_o != '1))
            ucnt_nxt = underflow_cnt_o + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q           <= '0;
            f_q             <= '0;
            init_cnt_q      <= '0;
            init_done_o     <= 1'b0;
            ready_o         <= 1'b0;
            tx_word_o       <= '0;
            hdr_err_o       <= 1'b0;
            underflow_cnt_o <= '0;
        end else begin
            buf_q           <= buf_nxt;
            f_q             <= f_nxt;
            init_cnt_q      <= init_cnt_nxt;
            init_done_o     <= init_done_nxt;
            ready_o         <= (f_nxt < FILL_W'(32)) & init_done_nxt;
            tx_word_o       <= comb_buf[BUF_W-1 -: 32];
            hdr_err_o       <= accept & (hdr_i[1] ~^ hdr_i[0]);
            underflow_cnt_o <= ucnt_nxt;
        end
    end

endmodule

// File: tb/tb_tx_frame_gearbox.sv
// Bench for tx_frame_gearbox: bit-stream scoreboard plus frame vector table and reset/underflow sequences.
module tb_tx_frame_gearbox;

    localparam logic [63:0] IDLE = 64'h7800_0000_0000_0000;
    localparam int INIT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        valid;
    logic        ready;
    logic [31:0] tx_word;
    logic        init_done;
    logic        hdr_err;
    logic [15:0] ucnt;

    logic        valid4;
    logic        ready4, init_done4, hdr_err4;
    logic [31:0] tx_word4;
    logic [3:0]  ucnt4;

    tx_frame_gearbox dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .hdr_i(hdr), .valid_i(valid),
        .ready_o(ready), .tx_word_o(tx_word), .init_done_o(init_done),
        .hdr_err_o(hdr_err), .underflow_cnt_o(ucnt)
    );

    tx_frame_gearbox #(.INIT_IDLES(2), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .hdr_i(hdr), .valid_i(valid4),
        .ready_o(ready4), .tx_word_o(tx_word4), .init_done_o(init_done4),
        .hdr_err_o(hdr_err4), .underflow_cnt_o(ucnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        err;
    } vec_t;
    vec_t vecs[48];

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    int          fm;
    int          m_init_cnt;
    bit          m_init_done, m_ready, m_err;
    logic [15:0] m_ucnt;
    logic [57:0] tb_scr;
    bit          exp_bits[$];

    int meas_left = 0;
    int rdy_cnt = 0;
    int acc_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        fm = 0; m_init_cnt = 0; m_init_done = 0; m_ready = 0; m_err = 0;
        m_ucnt = '0; tb_scr = '1;
        exp_bits.delete();
    endtask

    // One clock cycle: predict slot content, clock, compare the emitted word and status.
    task automatic step(output bit acc, output bit ld);
        logic [65:0] fr;
        logic [31:0] w;
        bit b;
        ld  = (fm < 32);
        acc = ld && m_ready && valid;
        if (meas_left > 0) begin
            meas_left--;
            if (ready) rdy_cnt++;
            if (acc) acc_cnt++;
        end
        if (ld) begin
            fr = acc ? {hdr, data} : {2'b10, IDLE};
`ifdef SCRAMBLER_EN
            for (int i = 63; i >= 0; i--) begin
                b = fr[i] ^ tb_scr[38] ^ tb_scr[57];
                fr[i] = b;
                tb_scr = {tb_scr[56:0], b};
            end
`endif
            for (int i = 65; i >= 0; i--) exp_bits.push_back(fr[i]);
            if (m_init_done && !valid && m_ucnt != 16'hFFFF) m_ucnt++;
            if (!m_init_done) begin
                m_init_cnt++;
                if (m_init_cnt == INIT) m_init_done = 1;
            end
        end
        m_err = acc && (hdr == 2'b00 || hdr == 2'b11);
        fm = ld ? fm + 34 : fm - 32;
        m_ready = (fm < 32) && m_init_done;
        @(posedge clk); #1;
        w = '0;
        if (exp_bits.size() < 32) begin
            check("stream_underrun", 64'(exp_bits.size()), 64'd32);
        end else begin
            for (int i = 31; i >= 0; i--) begin
                b = exp_bits.pop_front();
                w[i] = b;
            end
            check("tx_word", 64'(tx_word), 64'(w));
        end
        check("ready", 64'(ready), 64'(m_ready));
        check("init_done", 64'(init_done), 64'(m_init_done));
        check("hdr_err", 64'(hdr_err), 64'(m_err));
        check("underflow_cnt", 64'(ucnt), 64'(m_ucnt));
    endtask

    // Present one frame until accepted (bounded); returns whether it was accepted.
    task automatic send(input vec_t v, input int budget, output bit ok);
        bit acc, ld;
        hdr = v.hdr; data = v.data; valid = 1'b1;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            step(acc, ld);
            if (acc) ok = 1;
        end
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        bit ok, acc, ld;
        for (int i = 0; i < 48; i++) begin
            vecs[i].hdr  = (i % 2 == 0) ? 2'b01 : 2'b10;
            vecs[i].data = 64'h0123_4567_89AB_0000 + 64'(i);
            vecs[i].err  = 1'b0;
        end
        vecs[10].hdr = 2'b11; vecs[10].err = 1'b1;
        vecs[21].hdr = 2'b00; vecs[21].err = 1'b1;
        vecs[22].hdr = 2'b11; vecs[22].err = 1'b1;

        rst = 1'b1; valid = 1'b0; valid4 = 1'b0; data = '0; hdr = 2'b00;
        model_reset();
        #12;
        check("rst_tx_word", 64'(tx_word), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_hdr_err", 64'(hdr_err), 64'd0);
        check("rst_ucnt", 64'(ucnt), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Continuous valid through init, then the vector table.
        for (int i = 0; i < 48; i++) begin
            send(vecs[i], (i == 0) ? 120 : 4, ok);
            if (i == 0) meas_left = 33;
            if (ok) check("tbl_hdr_err", 64'(hdr_err), 64'(vecs[i].err));
        end
        check("rdy_per_33", 64'(rdy_cnt), 64'd16);
        check("acc_per_33", 64'(acc_cnt), 64'd16);
        check("no_underflow", 64'(ucnt), 64'd0);

        // Skip one load slot.
        valid = 1'b0;
        ld = 0;
        for (int c = 0; c < 4 && !ld; c++) step(acc, ld);
        check("underflow_one", 64'(ucnt), 64'd1);
        for (int i = 0; i < 6; i++) send(vecs[i], 4, ok);

        // Asynchronous reset mid-frame.
        hdr = vecs[1].hdr; data = vecs[1].data; valid = 1'b1;
        @(posedge clk); #3 rst = 1'b1; #1;
        check("mid_rst_tx_word", 64'(tx_word), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        check("mid_rst_init_done", 64'(init_done), 64'd0);
        check("mid_rst_ucnt", 64'(ucnt), 64'd0);
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) send(vecs[i], (i == 0) ? 120 : 4, ok);
        valid = 1'b0;
        for (int c = 0; c < 20; c++) step(acc, ld);

        check("sat_ucnt4", 64'(ucnt4), 64'hF);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
